// File: rtl/armleocpu_regfile_multiport.sv
// Parametrised multi-read-port register file for ArmleoCPU cores.
// After reset (or a software clear request) the array is swept to zero
// one entry per cycle while busy is high. Reads are registered. Same-cycle
// writes can optionally be forwarded to reads. Register 0 can optionally be
// hard-wired to zero.
module armleocpu_regfile_multiport #(
    parameter int WIDTH      = 32,
    parameter int ELEMENTS_W = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             busy,
    input  logic                             clear_req,
    input  logic [READ_PORTS-1:0]            rs_read,
    input  logic [READ_PORTS*ELEMENTS_W-1:0] rs_addr,
    output logic [READ_PORTS*WIDTH-1:0]      rs_rdata,
    input  logic                             rd_write,
    input  logic [ELEMENTS_W-1:0]            rd_addr,
    input  logic [WIDTH-1:0]                 rd_wdata
);

    localparam int DEPTH = 1 << ELEMENTS_W;

    typedef enum logic {
        StateClear,
        StateRun
    } state_t;

    state_t                    state_q;
    logic [ELEMENTS_W-1:0]     clearCount_q;
    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [READ_PORTS*WIDTH-1:0] readData_q;
    logic [READ_PORTS*WIDTH-1:0] readData_d;
    logic                      writeAccept;

    // A write only lands in RUN, and never targets a hard-wired zero register.
    assign writeAccept = (state_q == StateRun) && rd_write &&
                         !((ZERO_REG != 0) && (rd_addr == '0));

    assign busy     = (state_q == StateClear);
    assign rs_rdata = readData_q;

    // Clear/run sequencing: sweep every entry once, then accept traffic until a clear is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StateClear;
            clearCount_q <= '0;
        end else begin
            case (state_q)
                StateClear: begin
                    clearCount_q <= clearCount_q + ELEMENTS_W'(1);
                    if (clearCount_q == '1) begin
                        state_q <= StateRun;
                    end
                end
                StateRun: begin
                    if (clear_req) begin
                        state_q      <= StateClear;
                        clearCount_q <= '0;
                    end
                end
                default: begin
                    state_q      <= StateClear;
                    clearCount_q <= '0;
                end
            endcase
        end
    end

    // Single array write port shared between the clear sweep and normal writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StateClear) begin
                mem_q[clearCount_q] <= '0;
            end else if (writeAccept) begin
                mem_q[rd_addr] <= rd_wdata;
            end
        end
    end

    // Next read data per port: zero while clearing or for register 0, forwarded write data, else array contents.
    always_comb begin
        readData_d = readData_q;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (rs_read[p]) begin
                if (state_q == StateClear) begin
                    readData_d[p*WIDTH +: WIDTH] = '0;
                end else if ((ZERO_REG != 0) && (rs_addr[p*ELEMENTS_W +: ELEMENTS_W] == '0)) begin
                    readData_d[p*WIDTH +: WIDTH] = '0;
                end else if ((BYPASS != 0) && writeAccept &&
                             (rd_addr == rs_addr[p*ELEMENTS_W +: ELEMENTS_W])) begin
                    readData_d[p*WIDTH +: WIDTH] = rd_wdata;
                end else begin
                    readData_d[p*WIDTH +: WIDTH] = mem_q[rs_addr[p*ELEMENTS_W +: ELEMENTS_W]];
                end
            end
        end
    end

    // Registered read outputs; ports with rs_read low keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            readData_q <= '0;
        end else begin
            readData_q <= readData_d;
        end
    end

endmodule

// File: tb/tb_armleocpu_regfile_multiport.sv
// Testbench for armleocpu_regfile_multiport. Two instances share one set of
// inputs: dutA has a hard-wired zero register and bypass, dutB has neither.
// A behavioural model of the register file predicts every output each cycle.
module tb_armleocpu_regfile_multiport;

    localparam int Width     = 32;
    localparam int ElementsW = 5;
    localparam int Depth     = 32;
    localparam int Ports     = 4;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       clearReq;
    logic [Ports-1:0]           rsRead;
    logic [Ports*ElementsW-1:0] rsAddr;
    logic                       rdWrite;
    logic [ElementsW-1:0]       rdAddr;
    logic [Width-1:0]           rdWdata;
    logic                       busyA, busyB;
    logic [Ports*Width-1:0]     rdataA, rdataB;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 models dutA (zero reg + bypass), index 1 models dutB.
    logic [Width-1:0] memModel [2][Depth];
    logic [Width-1:0] expRd    [2][Ports];
    int               clearLeft = Depth;

    always #5 clock = ~clock;

    armleocpu_regfile_multiport #(
        .WIDTH(Width), .ELEMENTS_W(ElementsW), .READ_PORTS(Ports), .ZERO_REG(1), .BYPASS(1)
    ) dutA (
        .clk(clock), .rst(reset), .busy(busyA), .clear_req(clearReq),
        .rs_read(rsRead), .rs_addr(rsAddr), .rs_rdata(rdataA),
        .rd_write(rdWrite), .rd_addr(rdAddr), .rd_wdata(rdWdata)
    );

    armleocpu_regfile_multiport #(
        .WIDTH(Width), .ELEMENTS_W(ElementsW), .READ_PORTS(Ports), .ZERO_REG(0), .BYPASS(0)
    ) dutB (
        .clk(clock), .rst(reset), .busy(busyB), .clear_req(clearReq),
        .rs_read(rsRead), .rs_addr(rsAddr), .rs_rdata(rdataB),
        .rd_write(rdWrite), .rd_addr(rdAddr), .rd_wdata(rdWdata)
    );

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic [Ports*ElementsW-1:0] addr4(input logic [4:0] a0, input logic [4:0] a1,
                                                         input logic [4:0] a2, input logic [4:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Advance the reference model by one clock edge using the inputs sampled at that edge.
    task automatic updateModel(input logic r, input logic cr, input logic [3:0] rd,
                               input logic [19:0] ra, input logic w, input logic [4:0] wa,
                               input logic [31:0] wd);
        logic [4:0] a;
        bit zeroReg, bypass, wrOk;
        if (r) begin
            clearLeft = Depth;
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < Ports; p++) expRd[c][p] = '0;
        end else if (clearLeft > 0) begin
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < Ports; p++)
                    if (rd[p]) expRd[c][p] = '0;
                memModel[c][Depth - clearLeft] = '0;
            end
            clearLeft--;
        end else begin
            for (int c = 0; c < 2; c++) begin
                zeroReg = (c == 0);
                bypass  = (c == 0);
                wrOk    = w && !(zeroReg && wa == 0);
                for (int p = 0; p < Ports; p++) begin
                    a = ra[p*ElementsW +: ElementsW];
                    if (rd[p]) begin
                        if (zeroReg && a == 0)                 expRd[c][p] = '0;
                        else if (bypass && wrOk && wa == a)    expRd[c][p] = wd;
                        else                                   expRd[c][p] = memModel[c][a];
                    end
                end
                if (wrOk) memModel[c][wa] = wd;
            end
            if (cr) clearLeft = Depth;
        end
    endtask

    // Drive one cycle of inputs, step the model on the edge and compare all outputs just after it.
    task automatic applyStimulus(input logic r, input logic cr, input logic [3:0] rd,
                                 input logic [19:0] ra, input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd);
        reset = r; clearReq = cr; rsRead = rd; rsAddr = ra;
        rdWrite = w; rdAddr = wa; rdWdata = wd;
        @(posedge clock);
        updateModel(r, cr, rd, ra, w, wa, wd);
        #1;
        checkOutput("busyA", 32'(busyA), 32'(clearLeft > 0));
        checkOutput("busyB", 32'(busyB), 32'(clearLeft > 0));
        for (int p = 0; p < Ports; p++) begin
            checkOutput($sformatf("rdataA[%0d]", p), rdataA[p*Width +: Width], expRd[0][p]);
            checkOutput($sformatf("rdataB[%0d]", p), rdataB[p*Width +: Width], expRd[1][p]);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 4'h0, '0, 1'b0, 5'd0, 32'h0);
    endtask

    // Idle until busy drops (bounded) and check how many edges that took.
    task automatic waitClear(input string tag, input int expectedEdges);
        int n = 0;
        do begin
            idleCycle();
            n++;
        end while (busyA === 1'b1 && n < 100);
        checkOutput(tag, 32'(n), 32'(expectedEdges));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] ra [Ports];

        // Reset for three cycles, then the clear must take exactly 32 edges.
        repeat (3) applyStimulus(1'b1, 1'b0, 4'h0, '0, 1'b0, 5'd0, 32'h0);
        checkOutput("resetRdata", rdataA[31:0], 32'h0);
        checkOutput("resetBusy", 32'(busyA), 32'h1);
        waitClear("clearLen", 32);

        // Every address reads zero after the clear.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 4'hF,
                          addr4(5'(4*i), 5'(4*i+1), 5'(4*i+2), 5'(4*i+3)), 1'b0, 5'd0, 32'h0);
            for (int p = 0; p < Ports; p++)
                checkOutput("clearedZero", rdataB[p*Width +: Width], 32'h0);
        end

        // Data written before a reset is wiped by the following clear.
        applyStimulus(1'b0, 1'b0, 4'h0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 4'h1, addr4(5, 0, 0, 0), 1'b0, 5'd0, 32'h0);
        checkOutput("x5Written", rdataA[31:0], 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 4'h0, '0, 1'b0, 5'd0, 32'h0);
        waitClear("reclearLen", 32);
        applyStimulus(1'b0, 1'b0, 4'h1, addr4(5, 0, 0, 0), 1'b0, 5'd0, 32'h0);
        checkOutput("x5Cleared", rdataA[31:0], 32'h0);

        // Basic write then dual-port read of the same register.
        applyStimulus(1'b0, 1'b0, 4'h0, '0, 1'b1, 5'd7, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 4'h3, addr4(7, 7, 0, 0), 1'b0, 5'd0, 32'h0);
        checkOutput("x7Port0", rdataA[31:0], 32'h12345678);
        checkOutput("x7Port1", rdataA[63:32], 32'h12345678);

        // Outputs hold while rs_read is low, even when the register changes.
        applyStimulus(1'b0, 1'b0, 4'h0, addr4(7, 7, 0, 0), 1'b1, 5'd7, 32'hAAAA5555);
        applyStimulus(1'b0, 1'b0, 4'h0, addr4(7, 7, 0, 0), 1'b0, 5'd0, 32'h0);
        checkOutput("holdPort0", rdataA[31:0], 32'h12345678);
        checkOutput("holdPort1", rdataB[63:32], 32'h12345678);
        applyStimulus(1'b0, 1'b0, 4'h1, addr4(7, 7, 0, 0), 1'b0, 5'd0, 32'h0);
        checkOutput("rereadX7", rdataA[31:0], 32'hAAAA5555);
        checkOutput("stillHeld", rdataA[63:32], 32'h12345678);

        // Same-cycle write and read: forwarded in dutA, old value in dutB.
        applyStimulus(1'b0, 1'b0, 4'h2, addr4(0, 9, 0, 0), 1'b1, 5'd9, 32'hCAFEF00D);
        checkOutput("bypassOn", rdataA[63:32], 32'hCAFEF00D);
        checkOutput("bypassOff", rdataB[63:32], 32'h0);

        // Writes to register 0.
        applyStimulus(1'b0, 1'b0, 4'h1, addr4(0, 0, 0, 0), 1'b1, 5'd0, 32'hFFFFFFFF);
        checkOutput("x0SameZr", rdataA[31:0], 32'h0);
        checkOutput("x0SameNoZr", rdataB[31:0], 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h1, addr4(0, 0, 0, 0), 1'b0, 5'd0, 32'h0);
        checkOutput("x0NextZr", rdataA[31:0], 32'h0);
        checkOutput("x0NextNoZr", rdataB[31:0], 32'hFFFFFFFF);

        // Four ports reading four distinct registers.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 4'h0, '0, 1'b1, 5'(10 + i), 32'h1000_0000 * (i + 1) + 32'(i));
        applyStimulus(1'b0, 1'b0, 4'hF, addr4(10, 11, 12, 13), 1'b0, 5'd0, 32'h0);
        for (int p = 0; p < Ports; p++)
            checkOutput("fourPorts", rdataA[p*Width +: Width], 32'h1000_0000 * (p + 1) + 32'(p));

        // Software clear with a same-cycle write, then reset at clear cycle 10.
        applyStimulus(1'b0, 1'b1, 4'h0, '0, 1'b1, 5'd20, 32'h55);
        checkOutput("clearReqBusy", 32'(busyA), 32'h1);
        repeat (10) idleCycle();
        applyStimulus(1'b1, 1'b0, 4'h0, '0, 1'b0, 5'd0, 32'h0);
        waitClear("midClearReset", 32);

        // Writes and clear_req during CLEAR are ignored.
        applyStimulus(1'b1, 1'b0, 4'h0, '0, 1'b0, 5'd0, 32'h0);
        repeat (3) idleCycle();
        applyStimulus(1'b0, 1'b1, 4'h0, '0, 1'b1, 5'd3, 32'h1);
        waitClear("clearReqIgnored", 28);
        applyStimulus(1'b0, 1'b0, 4'h3, addr4(3, 7, 0, 0), 1'b0, 5'd0, 32'h0);
        checkOutput("x3Dropped", rdataB[31:0], 32'h0);
        checkOutput("x7Cleared", rdataB[63:32], 32'h0);

        // Randomised traffic with occasional resets and clear requests.
        for (int i = 0; i < 3000; i++) begin
            logic r, cr, w;
            logic [4:0] wa;
            r  = ($urandom_range(0, 299) == 0);
            cr = ($urandom_range(0, 79) == 0);
            w  = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            for (int p = 0; p < Ports; p++)
                ra[p] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            applyStimulus(r, cr, 4'($urandom), addr4(ra[0], ra[1], ra[2], ra[3]), w, wa, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
